// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux_bus_arbiter slice: state encoding, counter widths
// and the two-requester round-robin decision used from IDLE and at the end of TURN.
package mux_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  localparam int CNT_W  = 8;
  localparam int TURN_W = 4;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    OWN0 = ST_OWN0,
    OWN1 = ST_OWN1,
    TURN = ST_TURN
  } state_t;

  // On a tie the source that did not own the bus last wins.
  function automatic state_t arbitrate(input logic r0, input logic r1, input logic last_owner);
    if (r0 && r1) return last_owner ? OWN0 : OWN1;
    if (r0)       return OWN0;
    if (r1)       return OWN1;
    return IDLE;
  endfunction

endpackage

// File: rtl/mux_arb_counter.sv
// Loadable, clearable saturating up-counter used for hold time, turnaround
// length and the optional grant statistics. Priority: clear, load, increment.
module mux_arb_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               q <= '0;
    else if (clr)             q <= '0;
    else if (ld)              q <= ld_val;
    else if (inc && q != '1)  q <= q + 1'b1;
  end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Two-requester arbiter sequencing a 74S258-style tri-state mux with a bus-off
// turnaround between owners. Define MUX_BUS_ARBITER_STATS_EN for GCNT0/GCNT1.
module mux_bus_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ0,
  input  logic             REQ1,
  output logic             SEL,
  output logic             ENB_N,
  output logic             GNT0,
  output logic             GNT1,
  output logic             BUSY
`ifdef MUX_BUS_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] GCNT0,
  output logic [CNT_W-1:0] GCNT1
`endif
);

  state_t              state, state_nxt;
  logic                last_owner;
  logic [CNT_W-1:0]    hold_cnt;
  logic [TURN_W-1:0]   turn_cnt;
  logic                hold_limit, turn_last;
  logic                own_nxt, own_entry, turn_entry;
  logic                sel_nxt;

  assign hold_limit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign turn_last  = (turn_cnt == TURN_W'(TURN_CYCLES - 1));
  assign own_nxt    = (state_nxt == OWN0) || (state_nxt == OWN1);
  assign own_entry  = own_nxt && (state_nxt != state);
  assign turn_entry = (state_nxt == TURN) && (state != TURN);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = arbitrate(REQ0, REQ1, last_owner);
      OWN0: if (!REQ0 || (REQ1 && hold_limit)) state_nxt = REQ1 ? TURN : IDLE;
      OWN1: if (!REQ1 || (REQ0 && hold_limit)) state_nxt = REQ0 ? TURN : IDLE;
      TURN: if (turn_last) state_nxt = arbitrate(REQ0, REQ1, last_owner);
      default: state_nxt = IDLE;
    endcase
  end

  // SEL only moves when a new owner is granted; IDLE and TURN keep it parked.
  always_comb begin
    sel_nxt = SEL;
    if (state_nxt == OWN0)      sel_nxt = 1'b0;
    else if (state_nxt == OWN1) sel_nxt = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      SEL        <= 1'b0;
      ENB_N      <= 1'b1;
      GNT0       <= 1'b0;
      GNT1       <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == OWN0)      last_owner <= 1'b0;
      else if (state_nxt == OWN1) last_owner <= 1'b1;
      SEL   <= sel_nxt;
      ENB_N <= !own_nxt;
      GNT0  <= (state_nxt == OWN0);
      GNT1  <= (state_nxt == OWN1);
      BUSY  <= (state_nxt != IDLE);
    end
  end

  mux_arb_counter #(.W(CNT_W)) u_hold (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clr    (own_entry),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    ((state == OWN0) || (state == OWN1)),
    .q      (hold_cnt)
  );

  mux_arb_counter #(.W(TURN_W)) u_turn (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clr    (turn_entry),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (state == TURN),
    .q      (turn_cnt)
  );

`ifdef MUX_BUS_ARBITER_STATS_EN
  mux_arb_counter #(.W(CNT_W)) u_gcnt0 (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clr    (1'b0),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    ((state_nxt == OWN0) && (state != OWN0)),
    .q      (GCNT0)
  );

  mux_arb_counter #(.W(CNT_W)) u_gcnt1 (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clr    (1'b0),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    ((state_nxt == OWN1) && (state != OWN1)),
    .q      (GCNT1)
  );
`endif

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Bench for mux_bus_arbiter: u_dut0 uses TURN_CYCLES=1, u_dut1 uses TURN_CYCLES=3.
// Outputs are packed as {GNT0, GNT1, SEL, ENB_N, BUSY} for comparison.
module tb_mux_bus_arbiter;

  localparam logic [4:0] IDLE_S0 = 5'b00010;
  localparam logic [4:0] IDLE_S1 = 5'b00110;
  localparam logic [4:0] OWN0_E  = 5'b10001;
  localparam logic [4:0] OWN1_E  = 5'b01101;
  localparam logic [4:0] TURN_S0 = 5'b00011;
  localparam logic [4:0] TURN_S1 = 5'b00111;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0] outs;
    string      name;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_N;
  logic req0[2];
  logic req1[2];
  logic sel[2], enb_n[2], gnt0[2], gnt1[2], busy[2];
`ifdef MUX_BUS_ARBITER_STATS_EN
  logic [7:0] gcnt0[2], gcnt1[2];
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  vec_t tbl[25];
  logic prev_enb[2] = '{1'b1, 1'b1};
  logic prev_sel[2] = '{1'b0, 1'b0};

  always #5 CLK = ~CLK;

  mux_bus_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(1)) u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .REQ0(req0[0]), .REQ1(req1[0]),
    .SEL(sel[0]), .ENB_N(enb_n[0]), .GNT0(gnt0[0]), .GNT1(gnt1[0]), .BUSY(busy[0])
`ifdef MUX_BUS_ARBITER_STATS_EN
    , .GCNT0(gcnt0[0]), .GCNT1(gcnt1[0])
`endif
  );

  mux_bus_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(3)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .REQ0(req0[1]), .REQ1(req1[1]),
    .SEL(sel[1]), .ENB_N(enb_n[1]), .GNT0(gnt0[1]), .GNT1(gnt1[1]), .BUSY(busy[1])
`ifdef MUX_BUS_ARBITER_STATS_EN
    , .GCNT0(gcnt0[1]), .GCNT1(gcnt1[1])
`endif
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] pack(input int d);
    return {gnt0[d], gnt1[d], sel[d], enb_n[d], busy[d]};
  endfunction

  function automatic vec_t mk(input logic r0, input logic r1, input logic [4:0] e);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.exp = e;
    return v;
  endfunction

  // Drive one cycle of requests; the expected post-edge outputs ride the queue.
  task automatic drive(input int d, input logic r0, input logic r1,
                       input logic [4:0] e, input string name);
    exp_t x;
    req0[d] = r0;
    req1[d] = r1;
    x.outs = e;
    x.name = name;
    exp_q.push_back(x);
    @(posedge CLK);
    #1;
    x = exp_q.pop_front();
    check(x.name, 8'(pack(d)), 8'(x.outs));
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  // Bus-safety invariants on both instances every cycle.
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      check("no_dual_gnt", 8'(gnt0[d] & gnt1[d]), 8'd0);
      check("enb_vs_gnt", 8'(enb_n[d]), 8'(!(gnt0[d] ^ gnt1[d])));
      if (!prev_enb[d] && !enb_n[d])
        check("sel_stable", 8'(sel[d]), 8'(prev_sel[d]));
      prev_enb[d] = enb_n[d];
      prev_sel[d] = sel[d];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = mk(0, 0, IDLE_S0);
    tbl[1]  = mk(0, 0, IDLE_S0);
    tbl[2]  = mk(1, 0, OWN0_E);
    for (int i = 3; i < 10; i++) tbl[i] = mk(1, 0, OWN0_E);
    tbl[10] = mk(0, 0, IDLE_S0);
    tbl[11] = mk(0, 1, OWN1_E);
    tbl[12] = mk(0, 1, OWN1_E);
    tbl[13] = mk(0, 0, IDLE_S1);
    tbl[14] = mk(1, 0, OWN0_E);
    tbl[15] = mk(0, 0, IDLE_S0);
    tbl[16] = mk(1, 1, OWN1_E);
    tbl[17] = mk(0, 1, OWN1_E);
    tbl[18] = mk(1, 0, TURN_S1);
    tbl[19] = mk(1, 0, OWN0_E);
    tbl[20] = mk(0, 0, IDLE_S0);
    tbl[21] = mk(1, 1, OWN1_E);
    tbl[22] = mk(1, 0, TURN_S1);
    tbl[23] = mk(0, 1, OWN1_E);
    tbl[24] = mk(0, 0, IDLE_S1);

    RESET_N = 1'b0;
    req0 = '{1'b0, 1'b0};
    req1 = '{1'b0, 1'b0};
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) check("reset_state", 8'(pack(d)), 8'(IDLE_S0));
    RESET_N = 1'b1;

    for (int i = 0; i < 25; i++)
      drive(0, tbl[i].r0, tbl[i].r1, tbl[i].exp, $sformatf("vec%0d", i));

    // Both held from reset: 8 cycles each owner, one bus-off cycle between.
    apply_reset();
    for (int k = 0; k < 45; k++) begin
      int         p;
      logic [4:0] e;
      p = k / 9;
      if ((k % 9) < 8) e = (p % 2 == 1) ? OWN1_E : OWN0_E;
      else             e = (p % 2 == 1) ? TURN_S1 : TURN_S0;
      drive(0, 1, 1, e, $sformatf("alt%0d", k));
    end
`ifdef MUX_BUS_ARBITER_STATS_EN
    check("gcnt0", gcnt0[0], 8'd3);
    check("gcnt1", gcnt1[0], 8'd2);
`endif
    drive(0, 0, 0, IDLE_S0, "alt_release");

    drive(1, 1, 0, OWN0_E, "t3_own0");
    drive(1, 1, 1, OWN0_E, "t3_contend");
    for (int j = 0; j < 3; j++) drive(1, 0, 1, TURN_S0, $sformatf("t3_turn%0d", j));
    drive(1, 0, 1, OWN1_E, "t3_own1");
    drive(1, 0, 0, IDLE_S1, "t3_idle");

    for (int j = 0; j < 300; j++) drive(0, 1, 0, OWN0_E, $sformatf("solo%0d", j));
    check("hold_sat", u_dut0.hold_cnt, 8'd255);
    drive(0, 0, 0, IDLE_S0, "solo_release");

    // Asynchronous reset in the middle of an OWN1 grant.
    drive(0, 0, 1, OWN1_E, "ar_own1a");
    drive(0, 0, 1, OWN1_E, "ar_own1b");
    #3;
    RESET_N = 1'b0;
    #1;
    check("ar_async", 8'(pack(0)), 8'(IDLE_S0));
    @(posedge CLK);
    #1;
    check("ar_held", 8'(pack(0)), 8'(IDLE_S0));
    #4;
    RESET_N = 1'b1;
    drive(0, 0, 1, OWN1_E, "ar_regrant");
    drive(0, 0, 0, IDLE_S1, "ar_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
